// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one piezo buzzer between three tone requesters
// (doorbell, melody, key-click) by fixed priority with preemption, and
// generates the square wave for the BEEP pin from the owner's pitch divisor.
module buzzer_arbiter #(
    parameter int TICK_DIV = 50000,
    parameter int PITCH_W  = 17,
    parameter int DUR_W    = 12
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    input  logic [2:0]         REQ,
    input  logic [PITCH_W-1:0] PITCH0,
    input  logic [PITCH_W-1:0] PITCH1,
    input  logic [PITCH_W-1:0] PITCH2,
    input  logic [DUR_W-1:0]   DUR0,
    input  logic [DUR_W-1:0]   DUR1,
    input  logic [DUR_W-1:0]   DUR2,
    output logic [2:0]         GNT,
    output logic [2:0]         DONE,
    output logic [2:0]         ABORT,
    output logic               BUSY,
    output logic               BEEP,
    output logic [PITCH_W-1:0] CUR_PITCH
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP1, GAP2} state_t;

    state_t              state_q, state_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [2:0]          done_q, done_d;
    logic [2:0]          abort_q, abort_d;
    logic                busy_q, busy_d;
    logic                beep_q, beep_d;
    logic                tone_q, tone_d;
    logic [PITCH_W-1:0]  cur_pitch_q, cur_pitch_d;
    logic [PITCH_W-1:0]  half_cnt_q, half_cnt_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;

    logic [PITCH_W-1:0]  sel_pitch;
    logic [DUR_W-1:0]    sel_dur;
    logic                higher_req;
    logic                owner_drop;
    logic                tick_wrap;
    logic                half_wrap;

    // Route the current owner's pitch/duration to the capture logic used in LOAD
    always_comb begin
        sel_pitch = PITCH2;
        sel_dur   = DUR2;
        if (gnt_q[0]) begin
            sel_pitch = PITCH0;
            sel_dur   = DUR0;
        end else if (gnt_q[1]) begin
            sel_pitch = PITCH1;
            sel_dur   = DUR1;
        end
    end

    // Preempt/cancel detection and counter wrap conditions
    always_comb begin
        higher_req = (gnt_q[1] & REQ[0]) | (gnt_q[2] & (REQ[0] | REQ[1]));
        owner_drop = |(gnt_q & ~REQ);
        tick_wrap  = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        half_wrap  = (half_cnt_q == (cur_pitch_q - PITCH_W'(1)));
    end

    // Next-state, grant, tone and pulse logic; completion beats preemption
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 3'b000;
        abort_d     = 3'b000;
        cur_pitch_d = cur_pitch_q;
        half_cnt_d  = half_cnt_q;
        dur_cnt_d   = dur_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        tone_d      = tone_q;

        case (state_q)
            IDLE: begin
                if (REQ != 3'b000) begin
                    state_d = LOAD;
                    if (REQ[0])      gnt_d = 3'b001;
                    else if (REQ[1]) gnt_d = 3'b010;
                    else             gnt_d = 3'b100;
                end
            end
            LOAD: begin
                cur_pitch_d = sel_pitch;
                dur_cnt_d   = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
                tick_cnt_d  = '0;
                half_cnt_d  = '0;
                tone_d      = 1'b0;
                state_d     = PLAY;
                if (higher_req || owner_drop) begin
                    state_d     = GAP1;
                    abort_d     = gnt_q;
                    gnt_d       = 3'b000;
                    cur_pitch_d = '0;
                end
            end
            PLAY: begin
                tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
                if (tick_wrap) begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                end
                if (cur_pitch_q != '0) begin
                    if (half_wrap) begin
                        half_cnt_d = '0;
                        tone_d     = ~tone_q;
                    end else begin
                        half_cnt_d = half_cnt_q + PITCH_W'(1);
                    end
                end
                if (tick_wrap && (dur_cnt_q == DUR_W'(1))) begin
                    state_d     = GAP1;
                    done_d      = gnt_q;
                    gnt_d       = 3'b000;
                    cur_pitch_d = '0;
                end else if (higher_req || owner_drop) begin
                    state_d     = GAP1;
                    abort_d     = gnt_q;
                    gnt_d       = 3'b000;
                    cur_pitch_d = '0;
                end
            end
            GAP1: begin
                state_d = GAP2;
            end
            GAP2: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase

        busy_d = (state_d == LOAD) || (state_d == PLAY);
        beep_d = tone_d & EN & (state_d == PLAY);
    end

    // State and registered outputs, cleared immediately by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            abort_q     <= 3'b000;
            busy_q      <= 1'b0;
            beep_q      <= 1'b0;
            tone_q      <= 1'b0;
            cur_pitch_q <= '0;
            half_cnt_q  <= '0;
            dur_cnt_q   <= '0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            beep_q      <= beep_d;
            tone_q      <= tone_d;
            cur_pitch_q <= cur_pitch_d;
            half_cnt_q  <= half_cnt_d;
            dur_cnt_q   <= dur_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign GNT       = gnt_q;
    assign DONE      = done_q;
    assign ABORT     = abort_q;
    assign BUSY      = busy_q;
    assign BEEP      = beep_q;
    assign CUR_PITCH = cur_pitch_q;

endmodule
